// File: rtl/rr_select_seq4.sv
`default_nettype none
// ============================================================================
// Module   : rr_select_seq4
// Purpose  : Registered round-robin sequencer for four request lines. Drives
//            the 2-bit select ({a,b}) and active-low enable (en_n) of a
//            downstream 2-to-4 active-low decoder. Each grant is bounded by
//            MAX_HOLD cycles. After each grant en_n is forced high for
//            DEAD_CYC cycles, so two decoder strobes are never low in
//            consecutive cycles.
// Params   : MAX_HOLD  max grant length in cycles, 0 = unlimited (0..255)
//            DEAD_CYC  en_n-high gap after every grant (1..15)
// Ports    : clk      rising-edge clock
//            rst      asynchronous reset, active-high
//            req[3:0] level request per channel, held until served
//            done     holder releases (only looked at while granting)
//            a, b     registered select MSB / LSB
//            en_n     registered decoder enable, active-low
//            busy     registered, high while granting or in the dead gap
//            timeout  registered one-cycle pulse when MAX_HOLD ends a grant
// Revision : 1.0  initial release
// ============================================================================
module rr_select_seq4 #(
    parameter int MAX_HOLD = 16,
    parameter int DEAD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       a,
    output logic       b,
    output logic       en_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam bit         c_hold_en   = (MAX_HOLD != 0);
    localparam logic [7:0] c_hold_last = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam logic [3:0] c_gap_last  = 4'(DEAD_CYC - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [7:0] r_hold_cnt, w_hold_nxt;
    logic [3:0] r_gap_cnt, w_gap_nxt;
    logic       r_en_n, r_busy, r_timeout;
    logic       w_timeout_nxt;
    logic       w_found;
    logic [1:0] w_idx;
    logic       w_expire;

    // Search starts one past the last grantee and ends on the grantee itself,
    // so a lone holder that keeps requesting is granted again.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[r_ptr + k[1:0]]) begin
                w_found = 1'b1;
                w_idx   = r_ptr + k[1:0];
            end
        end
    end

    // hold_cnt counts completed grant cycles before this one, so the
    // MAX_HOLD-th cycle is the one where it equals MAX_HOLD-1.
    assign w_expire = c_hold_en && (r_hold_cnt == c_hold_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_hold_nxt    = r_hold_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_idx;
                    w_ptr_nxt   = w_idx;
                    w_hold_nxt  = 8'd0;
                end
            end
            S_GRANT: begin
                if (r_hold_cnt != 8'hFF) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
                if (done || !req[r_sel] || w_expire) begin
                    w_state_nxt   = S_GAP;
                    w_gap_nxt     = 4'd0;
                    // Expiry is reported even if done/withdrawal coincide.
                    w_timeout_nxt = w_expire;
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap_cnt + 4'd1;
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd3;
            r_sel      <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
            r_en_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sel      <= w_sel_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_en_n     <= (w_state_nxt != S_GRANT);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign a       = r_sel[1];
    assign b       = r_sel[0];
    assign en_n    = r_en_n;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_select_seq4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_select_seq4
// Purpose  : Self-checking bench for rr_select_seq4. Stimulus tasks push the
//            expected grant (channel, length, timeout) to a scoreboard; a
//            negedge monitor pops and compares when each grant ends.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_select_seq4;

    localparam int MAX_HOLD = 16;
    localparam int DEAD_CYC = 1;

    typedef struct {
        logic [1:0] ch;
        int         len;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       a, b, en_n, busy, timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    rr_select_seq4 #(
        .MAX_HOLD(MAX_HOLD),
        .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .a      (a),
        .b      (b),
        .en_n   (en_n),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a request from IDLE, end the grant with done after len cycles,
    // and check the gap and return to IDLE.
    task automatic grant_cycle(input logic [3:0] r, input logic [1:0] ch,
                               input int len, input bit clr);
        sb.push_back('{ch: ch, len: len, to: 1'b0});
        req = r;
        step(1);
        check("grant_en_n", 32'(en_n), 32'd0);
        check("grant_sel", 32'({a, b}), 32'(ch));
        check("grant_busy", 32'(busy), 32'd1);
        if (len > 1) step(len - 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        if (clr) req = r & ~(4'b0001 << ch);
        check("gap_en_n", 32'(en_n), 32'd1);
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_sel", 32'({a, b}), 32'(ch));
        check("gap_timeout", 32'(timeout), 32'd0);
        step(DEAD_CYC);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_en_n", 32'(en_n), 32'd1);
    endtask

    // Grant monitor: measures every en_n-low run against the scoreboard.
    logic       mon_prev_en_n = 1'b1;
    int         mon_high = 100;
    int         mon_len  = 0;
    logic [1:0] mon_ch   = 2'd0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev_en_n = 1'b1;
            mon_high      = 100;
            mon_len       = 0;
        end else begin
            if (!en_n) begin
                if (mon_prev_en_n) begin
                    check("gap_min", 32'(mon_high >= DEAD_CYC + 1), 32'd1);
                    mon_ch  = {a, b};
                    mon_len = 1;
                end else begin
                    mon_len++;
                    check("sel_stable", 32'({a, b}), 32'(mon_ch));
                end
            end else begin
                if (!mon_prev_en_n) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        mon_e = sb.pop_front();
                        check("sb_ch", 32'(mon_ch), 32'(mon_e.ch));
                        check("sb_len", 32'(mon_len), 32'(mon_e.len));
                        check("sb_timeout", 32'(timeout), 32'(mon_e.to));
                    end
                    mon_high = 1;
                end else begin
                    mon_high++;
                    if (timeout) check("timeout_spurious", 32'(timeout), 32'd0);
                end
            end
            mon_prev_en_n = en_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        step(2);
        check("rst_en_n", 32'(en_n), 32'd1);
        check("rst_sel", 32'({a, b}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        step(1);

        // T1: async reset in the middle of a ch2 grant.
        req = 4'b0100;
        step(1);
        check("t1_grant_en_n", 32'(en_n), 32'd0);
        check("t1_grant_sel", 32'({a, b}), 32'd2);
        step(1);
        #1 rst = 1'b1;
        #1;
        check("t1_async_en_n", 32'(en_n), 32'd1);
        check("t1_async_sel", 32'({a, b}), 32'd0);
        check("t1_async_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        step(1);
        rst = 1'b0;
        step(1);
        grant_cycle(4'b0001, 2'd0, 2, 1'b1);

        // T2: single request, done in the third grant cycle.
        grant_cycle(4'b0100, 2'd2, 3, 1'b1);

        // T4: timeout on ch3, then re-grant of the lone holder.
        sb.push_back('{ch: 2'd3, len: MAX_HOLD, to: 1'b1});
        req = 4'b1000;
        step(1);
        check("t4_en_n", 32'(en_n), 32'd0);
        check("t4_sel", 32'({a, b}), 32'd3);
        step(MAX_HOLD - 1);
        check("t4_last_en_n", 32'(en_n), 32'd0);
        check("t4_last_timeout", 32'(timeout), 32'd0);
        step(1);
        check("t4_exp_en_n", 32'(en_n), 32'd1);
        check("t4_exp_timeout", 32'(timeout), 32'd1);
        step(1);
        check("t4_pulse_end", 32'(timeout), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        sb.push_back('{ch: 2'd3, len: 2, to: 1'b0});
        step(1);
        check("t4_regrant_en_n", 32'(en_n), 32'd0);
        check("t4_regrant_sel", 32'({a, b}), 32'd3);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        req  = 4'b0000;
        step(DEAD_CYC);
        check("t4_final_busy", 32'(busy), 32'd0);

        // T3: all four requesting, rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            grant_cycle(4'b1111, 2'(i % 4), 1 + (i % 3), 1'b0);
        end
        req = 4'b0000;
        step(2);
        check("t3_quiet_en_n", 32'(en_n), 32'd1);

        // T5: holder ch1 withdraws while ch2 waits.
        sb.push_back('{ch: 2'd1, len: 3, to: 1'b0});
        req = 4'b0010;
        step(1);
        check("t5_sel", 32'({a, b}), 32'd1);
        step(2);
        req = 4'b0100;
        step(1);
        check("t5_wd_en_n", 32'(en_n), 32'd1);
        check("t5_wd_timeout", 32'(timeout), 32'd0);
        step(DEAD_CYC);
        check("t5_wd_busy", 32'(busy), 32'd0);
        grant_cycle(4'b0100, 2'd2, 1, 1'b1);

        // T6: set ptr=1, done in IDLE is inert, then wrap to ch0.
        grant_cycle(4'b0010, 2'd1, 1, 1'b1);
        done = 1'b1;
        step(2);
        done = 1'b0;
        check("t6_idle_done_en_n", 32'(en_n), 32'd1);
        check("t6_idle_done_busy", 32'(busy), 32'd0);
        grant_cycle(4'b0001, 2'd0, 2, 1'b1);

        step(3);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
